// File: rtl/switch_route_compute.sv
// Route-computation stage between the input VC buffers and the switch allocator.
// Each lane resolves head flits against route_lut, promotes the VC across the
// dateline, and holds the route for the body flits of the same packet.
// The package holds the flit and LUT entry layouts, which are shared with the
// surrounding switch.

package switch_route_pkg;

    localparam int DEST_W     = 4;
    localparam int LEN_W      = 8;
    localparam int VC_W       = 2;
    localparam int DATA_W     = 16;
    localparam int LUT_PORT_W = 3;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [LEN_W-1:0]  length;
        logic [VC_W-1:0]   vc;
        logic [DATA_W-1:0] data;
    } flit_t;

    typedef struct packed {
        logic                  valid;
        logic [DEST_W-1:0]     dest;
        logic [LUT_PORT_W-1:0] port;
    } route_lut_t;

endpackage

// Lane state table (one instance per buffer)
//   state   | meaning
//   ST_HEAD | next accepted flit is a head; look it up in route_lut
//   ST_BODY | r_remaining body flits still to come; reuse the latched route
module switch_route_compute
    import switch_route_pkg::*;
#(
    parameter  int NUM_BUFFERS  = 5,
    parameter  int NUM_OUTPORTS = 5,
    parameter  int TOTAL_NODES  = 4,
    parameter  int TABLE_SIZE   = 8,
    localparam int PORT_W       = $clog2(NUM_OUTPORTS)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  flit_t                   in_flit    [NUM_BUFFERS],
    input  logic [NUM_BUFFERS-1:0]  in_valid,
    output logic [NUM_BUFFERS-1:0]  in_ready,
    input  route_lut_t              route_lut  [TABLE_SIZE],
    input  logic [NUM_OUTPORTS-1:0] dateline,
    output flit_t                   out_flit   [NUM_BUFFERS],
    output logic [PORT_W-1:0]       out_port   [NUM_BUFFERS],
    output logic [NUM_BUFFERS-1:0]  out_valid,
    input  logic [NUM_BUFFERS-1:0]  out_ready,
    output logic [NUM_BUFFERS-1:0]  route_miss
);

    // Node IDs must fit the flit dest field and ports must fit the LUT port field.
    generate
        if (TOTAL_NODES > (1 << DEST_W) || PORT_W > LUT_PORT_W) begin : g_param_check
            $error("switch_route_compute: parameters do not fit the flit/LUT field widths");
        end
    endgenerate

    localparam int DL_W = 1 << PORT_W;

    typedef enum logic {
        ST_HEAD = 1'b0,
        ST_BODY = 1'b1
    } lane_state_t;

    lane_state_t            r_state          [NUM_BUFFERS];
    lane_state_t            w_state_nxt      [NUM_BUFFERS];
    logic [LEN_W-1:0]       r_remaining      [NUM_BUFFERS];
    logic [LEN_W-1:0]       w_remaining_nxt  [NUM_BUFFERS];
    logic [PORT_W-1:0]      r_route_port     [NUM_BUFFERS];
    logic [PORT_W-1:0]      w_route_port_nxt [NUM_BUFFERS];
    logic [VC_W-1:0]        r_route_vc       [NUM_BUFFERS];
    logic [VC_W-1:0]        w_route_vc_nxt   [NUM_BUFFERS];

    logic [NUM_BUFFERS-1:0] w_xfer;
    logic [NUM_BUFFERS-1:0] w_hit;
    logic [NUM_BUFFERS-1:0] w_miss_set;
    logic [PORT_W-1:0]      w_lut_port       [NUM_BUFFERS];
    logic [VC_W-1:0]        w_head_vc        [NUM_BUFFERS];
    logic [PORT_W-1:0]      w_port_sel       [NUM_BUFFERS];
    logic [VC_W-1:0]        w_vc_sel         [NUM_BUFFERS];
    flit_t                  w_flit_out       [NUM_BUFFERS];
    logic [DL_W-1:0]        w_dateline_ext;

    // Ready depends only on the output register state and the allocator's ready.
    assign in_ready = ~out_valid | out_ready;
    assign w_xfer   = in_valid & in_ready;

    // Table lookup for the flit at each buffer head; scanning downward lets the
    // lowest matching index overwrite any higher match.
    always_comb begin
        w_dateline_ext                 = '0;
        w_dateline_ext[NUM_OUTPORTS-1:0] = dateline;
        w_hit                          = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            w_lut_port[i] = '0;
            for (int j = TABLE_SIZE - 1; j >= 0; j--) begin
                if (route_lut[j].valid && (route_lut[j].dest == in_flit[i].dest)) begin
                    w_hit[i]      = 1'b1;
                    w_lut_port[i] = route_lut[j].port[PORT_W-1:0];
                end
            end
            // Ports beyond NUM_OUTPORTS see a zero dateline bit via the padding.
            w_head_vc[i] = w_dateline_ext[w_lut_port[i]] ? VC_W'(1) : in_flit[i].vc;
        end
    end

    // Lane next-state, route latch and output flit selection.
    always_comb begin
        w_miss_set = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            w_state_nxt[i]      = r_state[i];
            w_remaining_nxt[i]  = r_remaining[i];
            w_route_port_nxt[i] = r_route_port[i];
            w_route_vc_nxt[i]   = r_route_vc[i];
            w_port_sel[i]       = r_route_port[i];
            w_vc_sel[i]         = r_route_vc[i];

            case (r_state[i])
                ST_HEAD: begin
                    w_port_sel[i] = w_lut_port[i];
                    w_vc_sel[i]   = w_head_vc[i];
                    if (w_xfer[i]) begin
                        w_route_port_nxt[i] = w_lut_port[i];
                        w_route_vc_nxt[i]   = w_head_vc[i];
                        w_miss_set[i]       = ~w_hit[i];
                        if (in_flit[i].length != '0) begin
                            w_state_nxt[i]     = ST_BODY;
                            w_remaining_nxt[i] = in_flit[i].length;
                        end
                    end
                end
                ST_BODY: begin
                    if (w_xfer[i]) begin
                        if (r_remaining[i] != '0) begin
                            w_remaining_nxt[i] = r_remaining[i] - 1'b1;
                        end
                        if (r_remaining[i] <= LEN_W'(1)) begin
                            w_state_nxt[i] = ST_HEAD;
                        end
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_HEAD;
                end
            endcase

            w_flit_out[i]    = in_flit[i];
            w_flit_out[i].vc = w_vc_sel[i];
        end
    end

    // Lane state and latched route registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                r_state[i]      <= ST_HEAD;
                r_remaining[i]  <= '0;
                r_route_port[i] <= '0;
                r_route_vc[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                r_state[i]      <= w_state_nxt[i];
                r_remaining[i]  <= w_remaining_nxt[i];
                r_route_port[i] <= w_route_port_nxt[i];
                r_route_vc[i]   <= w_route_vc_nxt[i];
            end
        end
    end

    // Output register per lane: load on transfer, drain on ready, sticky miss flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid  <= '0;
            route_miss <= '0;
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                out_flit[i] <= '0;
                out_port[i] <= '0;
            end
        end else begin
            route_miss <= route_miss | w_miss_set;
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                if (w_xfer[i]) begin
                    out_flit[i]  <= w_flit_out[i];
                    out_port[i]  <= w_port_sel[i];
                    out_valid[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_route_compute.sv
// Bench for switch_route_compute: directed scenarios followed by random traffic,
// all checked every cycle against a packet-level reference model.
module tb_switch_route_compute;
    import switch_route_pkg::*;

    localparam int NB = 5;
    localparam int NO = 5;
    localparam int TS = 8;
    localparam int PW = 3;

    logic            clk;
    logic            n_rst;
    flit_t           in_flit   [NB];
    logic [NB-1:0]   in_valid;
    logic [NB-1:0]   in_ready;
    route_lut_t      route_lut [TS];
    logic [NO-1:0]   dateline;
    flit_t           out_flit  [NB];
    logic [PW-1:0]   out_port  [NB];
    logic [NB-1:0]   out_valid;
    logic [NB-1:0]   out_ready;
    logic [NB-1:0]   route_miss;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: expected output register and per-lane packet progress
    bit          m_valid [NB];
    flit_t       m_flit  [NB];
    logic [2:0]  m_port  [NB];
    bit          m_miss  [NB];
    int          m_left  [NB];   // body flits still expected; 0 => next is a head
    logic [2:0]  m_rport [NB];
    logic [1:0]  m_rvc   [NB];
    bit          m_acc   [NB];

    switch_route_compute #(
        .NUM_BUFFERS(NB), .NUM_OUTPORTS(NO), .TOTAL_NODES(4), .TABLE_SIZE(TS)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .route_lut(route_lut), .dateline(dateline),
        .out_flit(out_flit), .out_port(out_port), .out_valid(out_valid),
        .out_ready(out_ready), .route_miss(route_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic flit_t mk_flit(input int dest, input int len, input int vc, input int data);
        flit_t f;
        f.dest   = DEST_W'(dest);
        f.length = LEN_W'(len);
        f.vc     = VC_W'(vc);
        f.data   = DATA_W'(data);
        return f;
    endfunction

    function automatic route_lut_t mk_lut(input int v, input int dest, input int port);
        route_lut_t e;
        e.valid = v[0];
        e.dest  = DEST_W'(dest);
        e.port  = LUT_PORT_W'(port);
        return e;
    endfunction

    task automatic clear_lut();
        for (int j = 0; j < TS; j++) route_lut[j] = mk_lut(0, 0, 0);
    endtask

    // first valid entry with a matching destination, scanning from index 0
    task automatic ref_lookup(input logic [DEST_W-1:0] d, output logic [2:0] p, output bit hit);
        p   = 3'd0;
        hit = 1'b0;
        for (int j = 0; j < TS; j++) begin
            if (!hit && route_lut[j].valid && route_lut[j].dest == d) begin
                hit = 1'b1;
                p   = route_lut[j].port;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_valid[i] = 0; m_flit[i] = '0; m_port[i] = '0; m_miss[i] = 0;
            m_left[i] = 0; m_rport[i] = '0; m_rvc[i] = '0; m_acc[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NB; i++) begin
            check_val($sformatf("in_ready[%0d]", i), 64'(in_ready[i]), 64'(!m_valid[i] || out_ready[i]));
            check_val($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(m_valid[i]));
            check_val($sformatf("out_flit[%0d]", i), 64'(out_flit[i]), 64'(m_flit[i]));
            check_val($sformatf("out_port[%0d]", i), 64'(out_port[i]), 64'(m_port[i]));
            check_val($sformatf("route_miss[%0d]", i), 64'(route_miss[i]), 64'(m_miss[i]));
        end
    endtask

    // Advance one clock with the inputs currently driven, then check at the falling edge.
    task automatic cycle();
        logic [2:0] p;
        logic [1:0] vc;
        bit         hit;
        flit_t      nf;
        for (int i = 0; i < NB; i++) begin
            m_acc[i] = in_valid[i] && (!m_valid[i] || out_ready[i]);
            if (m_acc[i]) begin
                if (m_left[i] == 0) begin
                    ref_lookup(in_flit[i].dest, p, hit);
                    vc = (p < NO && dateline[p]) ? 2'd1 : in_flit[i].vc;
                    m_rport[i] = p;
                    m_rvc[i]   = vc;
                    m_left[i]  = int'(in_flit[i].length);
                    if (!hit) m_miss[i] = 1;
                end else begin
                    p  = m_rport[i];
                    vc = m_rvc[i];
                    m_left[i] = m_left[i] - 1;
                end
                nf         = in_flit[i];
                nf.vc      = vc;
                m_flit[i]  = nf;
                m_port[i]  = p;
                m_valid[i] = 1;
            end else if (out_ready[i]) begin
                m_valid[i] = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    flit_t bp_q[$];
    int    bp_acc;

    initial begin
        n_rst     = 1'b0;
        in_valid  = '0;
        out_ready = '1;
        dateline  = '0;
        for (int i = 0; i < NB; i++) in_flit[i] = '0;
        clear_lut();
        model_reset();
        @(negedge clk);
        check_all();
        #2 n_rst = 1'b1;

        // single-flit hit on lane 1
        route_lut[2] = mk_lut(1, 3, 4);
        in_flit[1] = mk_flit(3, 0, 0, 16'h1111);
        in_valid   = 5'b00010;
        cycle();
        check_val("hit_port", 64'(out_port[1]), 64'd4);
        check_val("hit_vc", 64'(out_flit[1].vc), 64'd0);
        in_valid = '0;
        cycle();

        // multi-flit route latch with a LUT change after the head
        in_flit[1] = mk_flit(3, 3, 2, 16'h2000);
        in_valid   = 5'b00010;
        cycle();
        route_lut[2] = mk_lut(1, 3, 2);
        for (int k = 1; k <= 3; k++) begin
            in_flit[1] = mk_flit(0, 7, 3, 16'h2000 + k);
            cycle();
            check_val("latch_port", 64'(out_port[1]), 64'd4);
        end
        in_flit[1] = mk_flit(3, 0, 0, 16'h2004);
        cycle();
        check_val("new_head_port", 64'(out_port[1]), 64'd2);
        in_valid = '0;
        cycle();

        // priority and dateline promotion on lane 0
        clear_lut();
        route_lut[0] = mk_lut(1, 1, 2);
        route_lut[5] = mk_lut(1, 1, 3);
        dateline     = 5'b00100;
        in_flit[0]   = mk_flit(1, 0, 0, 16'h3000);
        in_valid     = 5'b00001;
        cycle();
        check_val("prio_port", 64'(out_port[0]), 64'd2);
        check_val("dl_vc", 64'(out_flit[0].vc), 64'd1);
        dateline   = '0;
        in_flit[0] = mk_flit(1, 0, 0, 16'h3001);
        cycle();
        check_val("nodl_vc", 64'(out_flit[0].vc), 64'd0);
        in_valid = '0;
        cycle();

        // miss on lane 4, then ten hitting packets
        in_flit[4] = mk_flit(2, 0, 1, 16'h4000);
        in_valid   = 5'b10000;
        cycle();
        check_val("miss_port", 64'(out_port[4]), 64'd0);
        check_val("miss_flag", 64'(route_miss[4]), 64'd1);
        for (int k = 0; k < 10; k++) begin
            in_flit[4] = mk_flit(1, 0, 0, 16'h4001 + k);
            cycle();
        end
        check_val("miss_sticky", 64'(route_miss[4]), 64'd1);
        in_valid = '0;
        cycle();

        // backpressure on lane 2: 6-flit packet, out_ready low for cycles 2..4
        bp_q.push_back(mk_flit(1, 5, 0, 16'h5000));
        for (int k = 1; k < 6; k++) bp_q.push_back(mk_flit(k, 9, 2, 16'h5000 + k));
        bp_acc = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid[2]  = (bp_q.size() > 0);
            if (bp_q.size() > 0) in_flit[2] = bp_q[0];
            out_ready[2] = !(k >= 2 && k <= 4);
            cycle();
            if (k >= 3 && k <= 4) check_val("bp_in_ready", 64'(in_ready[2]), 64'd0);
            if (m_acc[2]) begin
                void'(bp_q.pop_front());
                bp_acc++;
            end
        end
        check_val("bp_accepted", 64'(bp_acc), 64'd6);
        in_valid  = '0;
        out_ready = '1;
        cycle();

        // lanes 0 and 3 concurrently
        route_lut[1] = mk_lut(1, 2, 3);
        in_flit[0] = mk_flit(1, 2, 0, 16'h6000);
        in_flit[3] = mk_flit(2, 1, 1, 16'h6100);
        in_valid   = 5'b01001;
        cycle();
        check_val("lane0_port", 64'(out_port[0]), 64'd2);
        check_val("lane3_port", 64'(out_port[3]), 64'd3);
        in_flit[0] = mk_flit(2, 0, 0, 16'h6001);
        in_flit[3] = mk_flit(1, 0, 1, 16'h6101);
        cycle();
        check_val("lane0_body", 64'(out_port[0]), 64'd2);
        check_val("lane3_tail", 64'(out_port[3]), 64'd3);
        in_flit[0] = mk_flit(2, 0, 0, 16'h6002);
        in_flit[3] = mk_flit(1, 0, 0, 16'h6102);
        cycle();
        check_val("lane0_tail", 64'(out_port[0]), 64'd2);
        check_val("lane3_head", 64'(out_port[3]), 64'd2);
        in_valid = '0;
        cycle();

        // reset in the middle of a body on lane 0
        in_flit[0] = mk_flit(1, 5, 0, 16'h7000);
        in_valid   = 5'b00001;
        cycle();
        in_flit[0] = mk_flit(1, 0, 0, 16'h7001);
        cycle();
        #2 n_rst = 1'b0;
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        model_reset();
        #2 n_rst = 1'b1;
        in_flit[0] = mk_flit(2, 0, 0, 16'h7002);
        cycle();
        check_val("post_rst_head", 64'(out_port[0]), 64'd3);
        in_valid = '0;
        cycle();

        // random traffic, LUT and dateline reshuffled periodically (often mid-packet)
        for (int c = 0; c < 2000; c++) begin
            if (c % 50 == 0) begin
                for (int j = 0; j < TS; j++)
                    route_lut[j] = mk_lut($urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(0, 4));
                dateline = NO'($urandom);
            end
            for (int i = 0; i < NB; i++) begin
                if (m_acc[i] || !in_valid[i]) begin
                    in_valid[i] = ($urandom_range(0, 3) != 0);
                    in_flit[i]  = mk_flit($urandom_range(0, 4), $urandom_range(0, 3),
                                          $urandom_range(0, 3), $urandom_range(0, 65535));
                end
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
